// File: rtl/pool_pkg.sv
// Shared definitions for the 2x2 max-pool / ReLU stage.
//   POOL_OUT_W/H/NUM_CH : default pooled-map geometry
//   MAX2_W              : working width of the generic signed max helper
//   idx_w()             : index width for a count, never below 1 bit
//   max2()              : signed maximum, ties resolve to the common value
package pool_pkg;

    localparam int POOL_OUT_W  = 14;
    localparam int POOL_OUT_H  = 14;
    localparam int POOL_NUM_CH = 6;
    localparam int MAX2_W      = 32;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic signed [MAX2_W-1:0] max2(input logic signed [MAX2_W-1:0] x,
                                                      input logic signed [MAX2_W-1:0] y);
        return (x >= y) ? x : y;
    endfunction

endpackage

// File: rtl/pool_index_counter.sv
// Position counters for the pooled feature map.
//   clk, reset (async, active-low), clear (sync restart)
//   adv   : a result leaves the pipeline this cycle, step to the next position
//   col/row/ch/addr : position of the next result to be emitted
//   last  : current position is the final one of the frame
module pool_index_counter
    import pool_pkg::*;
#(
    parameter int OUT_W  = POOL_OUT_W,
    parameter int OUT_H  = POOL_OUT_H,
    parameter int NUM_CH = POOL_NUM_CH,
    parameter int COL_W  = idx_w(OUT_W),
    parameter int ROW_W  = idx_w(OUT_H),
    parameter int CH_W   = idx_w(NUM_CH),
    parameter int ADDR_W = $clog2(NUM_CH*OUT_H*OUT_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              adv,
    output logic [COL_W-1:0]  col,
    output logic [ROW_W-1:0]  row,
    output logic [CH_W-1:0]   ch,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic col_end;
    logic row_end;
    logic ch_end;

    assign col_end = (col == COL_W'(OUT_W-1));
    assign row_end = (row == ROW_W'(OUT_H-1));
    assign ch_end  = (ch  == CH_W'(NUM_CH-1));
    assign last    = col_end && row_end && ch_end;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col  <= '0;
            row  <= '0;
            ch   <= '0;
            addr <= '0;
        end else if (clear) begin
            col  <= '0;
            row  <= '0;
            ch   <= '0;
            addr <= '0;
        end else if (adv) begin
            // The flat address is row-major over (ch,row,col), so it simply
            // counts results and only returns to zero at the end of a frame.
            addr <= last ? '0 : addr + ADDR_W'(1);
            if (col_end) begin
                col <= '0;
                if (row_end) begin
                    row <= '0;
                    ch  <= ch_end ? '0 : ch + CH_W'(1);
                end else begin
                    row <= row + ROW_W'(1);
                end
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

endmodule

// File: rtl/pool_max_relu.sv
// 2x2 max pooling with optional ReLU and pooled-map addressing.
//   clk, reset (async, active-low), clear (sync frame restart)
//   flag_trans, a..d : one signed 2x2 window per strobe
//   data_out, valid_out : pooled result, two cycles after the strobe
//   ch_idx/row_idx/col_idx/addr : position of data_out in the pooled map
//   frame_done : accompanies the last result of a frame
module pool_max_relu
    import pool_pkg::*;
#(
    parameter int bitwidth = 17,
    parameter int OUT_W    = POOL_OUT_W,
    parameter int OUT_H    = POOL_OUT_H,
    parameter int NUM_CH   = POOL_NUM_CH,
    parameter int RELU_EN  = 1,
    parameter int ADDR_W   = $clog2(NUM_CH*OUT_H*OUT_W),
    parameter int CH_W     = idx_w(NUM_CH),
    parameter int ROW_W    = idx_w(OUT_H),
    parameter int COL_W    = idx_w(OUT_W)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       flag_trans,
    input  logic signed [bitwidth-1:0] a,
    input  logic signed [bitwidth-1:0] b,
    input  logic signed [bitwidth-1:0] c,
    input  logic signed [bitwidth-1:0] d,
    output logic signed [bitwidth-1:0] data_out,
    output logic                       valid_out,
    output logic [CH_W-1:0]            ch_idx,
    output logic [ROW_W-1:0]           row_idx,
    output logic [COL_W-1:0]           col_idx,
    output logic [ADDR_W-1:0]          addr,
    output logic                       frame_done
);

    function automatic logic signed [MAX2_W-1:0] sx(input logic signed [bitwidth-1:0] v);
        return {{(MAX2_W-bitwidth){v[bitwidth-1]}}, v};
    endfunction

    function automatic logic signed [bitwidth-1:0] relu(input logic signed [bitwidth-1:0] v);
        if ((RELU_EN != 0) && v[bitwidth-1])
            return '0;
        return v;
    endfunction

    logic signed [MAX2_W-1:0]   m0_w;
    logic signed [MAX2_W-1:0]   m1_w;
    logic signed [MAX2_W-1:0]   m_w;
    logic signed [bitwidth-1:0] m0_p1;
    logic signed [bitwidth-1:0] m1_p1;
    logic                       vld_p1;

    logic [COL_W-1:0]  cnt_col;
    logic [ROW_W-1:0]  cnt_row;
    logic [CH_W-1:0]   cnt_ch;
    logic [ADDR_W-1:0] cnt_addr;
    logic              cnt_last;

    assign m0_w = max2(sx(a), sx(b));
    assign m1_w = max2(sx(c), sx(d));
    assign m_w  = max2(sx(m0_p1), sx(m1_p1));

    // ---- stage 1: pairwise max of the window ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            vld_p1 <= 1'b0;
        else if (clear)
            vld_p1 <= 1'b0;
        else
            vld_p1 <= flag_trans;
    end

    always_ff @(posedge clk) begin
        if (flag_trans) begin
            m0_p1 <= m0_w[bitwidth-1:0];
            m1_p1 <= m1_w[bitwidth-1:0];
        end
    end

    // ---- stage 2: final max, ReLU, position tagging ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out   <= '0;
            valid_out  <= 1'b0;
            ch_idx     <= '0;
            row_idx    <= '0;
            col_idx    <= '0;
            addr       <= '0;
            frame_done <= 1'b0;
        end else if (clear) begin
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            valid_out  <= vld_p1;
            frame_done <= vld_p1 && cnt_last;
            if (vld_p1) begin
                data_out <= relu(m_w[bitwidth-1:0]);
                ch_idx   <= cnt_ch;
                row_idx  <= cnt_row;
                col_idx  <= cnt_col;
                addr     <= cnt_addr;
            end
        end
    end

    // Counters step on the same edge that publishes their value.
    pool_index_counter #(
        .OUT_W  (OUT_W),
        .OUT_H  (OUT_H),
        .NUM_CH (NUM_CH),
        .COL_W  (COL_W),
        .ROW_W  (ROW_W),
        .CH_W   (CH_W),
        .ADDR_W (ADDR_W)
    ) u_idx (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .adv   (vld_p1),
        .col   (cnt_col),
        .row   (cnt_row),
        .ch    (cnt_ch),
        .addr  (cnt_addr),
        .last  (cnt_last)
    );

endmodule
